gf_poly_eval_seq: RTL and testbench
===================================

GF_POLY_EVAL_SEQ -- requirements
Module: gf_poly_eval_seq

Interface
REQ-001 Parameter SYMB_WIDTH, default gf_pkg SYMB_WIDTH (8), symbol width in bits.
REQ-002 Parameter POLY, default gf_pkg POLY (285), field primitive polynomial including the x^SYMB_WIDTH term.
REQ-003 Parameter DEG_MAX, default gf_pkg T_LEN (8), maximum polynomial degree.
REQ-004 Parameter LANES, default gf_pkg BUS_WIDTH_IN_SYMB (4), number of evaluation points processed in parallel.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  transaction request.
REQ-008 in_ready  output  1  block can accept a transaction.
REQ-009 in_coef  input  (DEG_MAX+1)*SYMB_WIDTH  coefficients; index i is the x^i coefficient.
REQ-010 in_deg  input  clog2(DEG_MAX+1)  degree of this transaction.
REQ-011 in_x  input  LANES*SYMB_WIDTH  one evaluation point per lane.
REQ-012 out_valid  output  1  results available.
REQ-013 out_ready  input  1  consumer accepts results.
REQ-014 out_val  output  LANES*SYMB_WIDTH  p(x) for each lane.
REQ-015 out_zero  output  LANES  per-lane root flag; present only with GF_EVAL_ZERO_FLAG_EN.

Function
REQ-016 Handshake rule: a transfer occurs on any edge where valid and ready are both high.
REQ-017 The block SHALL use a three-state FSM: IDLE, EVAL and DONE.
REQ-018 in_ready SHALL be high exactly when the state is IDLE; the block SHALL NOT accept a new transaction in the cycle that DONE is released.
REQ-019 On an input transfer, the block SHALL capture in_coef and in_x, set acc[l] = coef[deg] and cnt = deg, and go to EVAL if deg>=1, otherwise to DONE.
REQ-020 If in_deg > DEG_MAX, the block SHALL saturate the degree to DEG_MAX.
REQ-021 In each EVAL cycle, the block SHALL compute acc[l] = gf_mult(acc[l], x[l]) XOR coef[cnt-1] and decrement cnt; when cnt reaches 1, it SHALL go to DONE (Horner evaluation).
REQ-022 out_valid SHALL assert exactly deg+1 cycles after the input transfer cycle; for deg=0 this is 1 cycle.
REQ-023 In DONE, out_valid=1 and out_val=acc SHALL be held stable until out_ready; on the output transfer the FSM SHALL return to IDLE.
REQ-024 GF multiplication SHALL be a single-cycle combinational shift-and-XOR reduction modulo POLY, with no LUT; if either operand is 0 the product is 0.
REQ-025 x=0 SHALL produce out_val = coef[0].
REQ-026 x=1 SHALL produce the XOR of coef[0..deg].
REQ-027 All lanes SHALL share cnt and the FSM; lanes differ only in x and acc.
REQ-028 Combinational paths from inputs to outputs SHALL NOT exist.

Reset
REQ-029 While rst is high, the block SHALL hold state=IDLE, cnt=0, acc=0, in_ready=1, out_valid=0, out_val=0, out_zero=0.
REQ-030 Reset asserted in EVAL or DONE SHALL abort the transaction and discard its results; the first transfer after reset release SHALL be processed normally.

Configuration
REQ-031 With macro GF_EVAL_ZERO_FLAG_EN defined, the block SHALL register out_zero[l] = (acc[l]==0) on entry to DONE, valid under out_valid.
REQ-032 Without GF_EVAL_ZERO_FLAG_EN, the out_zero port and its logic SHALL be absent.

Structure
REQ-033 gf_pkg SHALL hold SYMB_WIDTH, POLY, T_LEN, BUS_WIDTH_IN_SYMB, symb_t, and a new typedef eval_state_t (IDLE/EVAL/DONE).
REQ-034 gf_pkg SHALL hold a new parametrised coefficient-array typedef sized DEG_MAX+1.
REQ-035 A sub-module gf_mult_comb (SYMB_WIDTH, POLY) SHALL implement the combinational multiplier and be instantiated LANES times.

Verification
REQ-036 Scenario 1: coef={1,1}, deg=1, x={2,4,0,1} -> out_val={3,5,1,0}, out_valid 2 cycles after the transfer.
REQ-037 Scenario 2: coef[8]=1, others 0, deg=8, x=2 in all lanes -> out_val=0x1D in every lane, latency 9.
REQ-038 Scenario 3: coef={8,6,1}, deg=2, x={2,4,3,0} -> out_val lanes 0,1 = 0, lane 3 = 8; out_zero=4'b0011 with the macro defined.
REQ-039 Scenario 4: out_ready held low 5 cycles in DONE -> out_val stable and in_ready=0 throughout; in_ready=1 the cycle after out_ready.
REQ-040 Scenario 5: deg=12 with DEG_MAX=8 -> treated as deg=8, latency 9; deg=0 -> out_val=coef[0], latency 1.
REQ-041 Scenario 6: rst pulsed at EVAL cycle 3 -> out_valid never asserts for that transaction; the next transaction gives the correct result.

Source files
------------

// File: rtl/gf_pkg.sv
// gf_pkg: shared field parameters, symbol type and the evaluator state type
// used by the GF polynomial evaluator and its multiplier.
package gf_pkg;

    localparam int SYMB_WIDTH        = 8;
    localparam int POLY              = 285;
    localparam int T_LEN             = 8;
    localparam int BUS_WIDTH_IN_SYMB = 4;

    typedef logic [SYMB_WIDTH-1:0] symb_t;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        DONE
    } eval_state_t;

    // Coefficient array for the default configuration (DEG_MAX = T_LEN).
    // Modules with a different DEG_MAX declare a local array of DEG_MAX+1
    // entries with the same shape.
    typedef symb_t coef_arr_t [T_LEN+1];

endpackage

// File: rtl/gf_poly_eval_seq_if.sv
// gf_poly_eval_seq_if: request/result bundle of the GF polynomial evaluator.
// The out_zero lane flags exist only when GF_EVAL_ZERO_FLAG_EN is defined.
interface gf_poly_eval_seq_if #(
    parameter int SYMB_WIDTH = gf_pkg::SYMB_WIDTH,
    parameter int DEG_MAX    = gf_pkg::T_LEN,
    parameter int LANES      = gf_pkg::BUS_WIDTH_IN_SYMB
);

    localparam int DEG_W = $clog2(DEG_MAX + 1);

    logic                              in_valid;
    logic                              in_ready;
    logic [(DEG_MAX+1)*SYMB_WIDTH-1:0] in_coef;
    logic [DEG_W-1:0]                  in_deg;
    logic [LANES*SYMB_WIDTH-1:0]       in_x;
    logic                              out_valid;
    logic                              out_ready;
    logic [LANES*SYMB_WIDTH-1:0]       out_val;
`ifdef GF_EVAL_ZERO_FLAG_EN
    logic [LANES-1:0]                  out_zero;
`endif

    modport master (
        output in_valid, in_coef, in_deg, in_x, out_ready,
`ifdef GF_EVAL_ZERO_FLAG_EN
        input  out_zero,
`endif
        input  in_ready, out_valid, out_val
    );

    modport slave (
        input  in_valid, in_coef, in_deg, in_x, out_ready,
`ifdef GF_EVAL_ZERO_FLAG_EN
        output out_zero,
`endif
        output in_ready, out_valid, out_val
    );

endinterface

// File: rtl/gf_mult_comb.sv
// gf_mult_comb: single-cycle GF(2^SYMB_WIDTH) multiplier built from a
// shift-and-XOR chain reduced modulo POLY; no lookup tables.
module gf_mult_comb #(
    parameter int SYMB_WIDTH = gf_pkg::SYMB_WIDTH,
    parameter int POLY       = gf_pkg::POLY
) (
    input  logic [SYMB_WIDTH-1:0] a,
    input  logic [SYMB_WIDTH-1:0] b,
    output logic [SYMB_WIDTH-1:0] p
);

    // Low bits of the primitive polynomial, folded in when a shift overflows.
    localparam logic [SYMB_WIDTH-1:0] RED = SYMB_WIDTH'(POLY);

    logic [SYMB_WIDTH-1:0] prod;
    logic [SYMB_WIDTH-1:0] shifted;

    // Walk the bits of b, adding a*x^i for every set bit while keeping a*x^i reduced.
    always_comb begin
        prod    = '0;
        shifted = a;
        for (int i = 0; i < SYMB_WIDTH; i++) begin
            if (b[i]) begin
                prod = prod ^ shifted;
            end
            shifted = {shifted[SYMB_WIDTH-2:0], 1'b0} ^ (shifted[SYMB_WIDTH-1] ? RED : '0);
        end
    end

    assign p = prod;

endmodule

// File: rtl/gf_poly_eval_seq.sv
// gf_poly_eval_seq: evaluates one polynomial over GF(2^SYMB_WIDTH) at LANES
// points in parallel using Horner's rule, one coefficient per cycle.
// Optional feature: define GF_EVAL_ZERO_FLAG_EN to add per-lane root flags
// (out_zero) registered on entry to DONE.
module gf_poly_eval_seq
    import gf_pkg::*;
#(
    parameter int SYMB_WIDTH = gf_pkg::SYMB_WIDTH,
    parameter int POLY       = gf_pkg::POLY,
    parameter int DEG_MAX    = gf_pkg::T_LEN,
    parameter int LANES      = gf_pkg::BUS_WIDTH_IN_SYMB
) (
    input  logic              clk,
    input  logic              rst,
    gf_poly_eval_seq_if.slave bus
);

    localparam int DEG_W = $clog2(DEG_MAX + 1);
    localparam logic [DEG_W-1:0] DEG_MAX_V = DEG_W'(DEG_MAX);
    localparam logic [DEG_W-1:0] ONE_V     = DEG_W'(1);

    typedef logic [SYMB_WIDTH-1:0] sym_t;

    eval_state_t      state;
    eval_state_t      state_nxt;
    logic [DEG_W-1:0] cnt;
    logic [DEG_W-1:0] cnt_nxt;
    logic [DEG_W-1:0] cnt_m1;
    logic [DEG_W-1:0] deg_sat;
    logic             take_in;

    sym_t coef_in  [DEG_MAX+1];
    sym_t coef_reg [DEG_MAX+1];
    sym_t x_in     [LANES];
    sym_t x_reg    [LANES];
    sym_t acc      [LANES];
    sym_t acc_nxt  [LANES];
    sym_t prod     [LANES];

    // Unpack the flat request buses and clamp an oversized degree to DEG_MAX.
    always_comb begin
        for (int i = 0; i <= DEG_MAX; i++) begin
            coef_in[i] = bus.in_coef[i*SYMB_WIDTH +: SYMB_WIDTH];
        end
        for (int l = 0; l < LANES; l++) begin
            x_in[l] = bus.in_x[l*SYMB_WIDTH +: SYMB_WIDTH];
        end
        deg_sat = (bus.in_deg > DEG_MAX_V) ? DEG_MAX_V : bus.in_deg;
    end

    assign take_in = bus.in_valid && (state == IDLE);
    assign cnt_m1  = cnt - ONE_V;

    // One multiplier per lane: acc times that lane's evaluation point.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        gf_mult_comb #(
            .SYMB_WIDTH(SYMB_WIDTH),
            .POLY      (POLY)
        ) u_mult (
            .a(acc[l]),
            .b(x_reg[l]),
            .p(prod[l])
        );
    end

    // State register; reset drops any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: degree 0 skips EVAL, otherwise EVAL runs until cnt hits 1.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (take_in) begin
                    state_nxt = (deg_sat == '0) ? DONE : EVAL;
                end
            end
            EVAL: begin
                if (cnt == ONE_V) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Horner step: load the leading coefficient, then fold in one lower coefficient per cycle.
    always_comb begin
        cnt_nxt = cnt;
        acc_nxt = acc;
        if (take_in) begin
            cnt_nxt = deg_sat;
            for (int l = 0; l < LANES; l++) begin
                acc_nxt[l] = coef_in[deg_sat];
            end
        end else if (state == EVAL) begin
            cnt_nxt = cnt_m1;
            for (int l = 0; l < LANES; l++) begin
                acc_nxt[l] = prod[l] ^ coef_reg[cnt_m1];
            end
        end
    end

    // Datapath registers: operands captured on the input transfer, accumulators every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            for (int i = 0; i <= DEG_MAX; i++) begin
                coef_reg[i] <= '0;
            end
            for (int l = 0; l < LANES; l++) begin
                x_reg[l] <= '0;
                acc[l]   <= '0;
            end
        end else begin
            cnt <= cnt_nxt;
            for (int l = 0; l < LANES; l++) begin
                acc[l] <= acc_nxt[l];
            end
            if (take_in) begin
                for (int i = 0; i <= DEG_MAX; i++) begin
                    coef_reg[i] <= coef_in[i];
                end
                for (int l = 0; l < LANES; l++) begin
                    x_reg[l] <= x_in[l];
                end
            end
        end
    end

    // Outputs come straight from registers so no input reaches an output combinationally.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            bus.out_val[l*SYMB_WIDTH +: SYMB_WIDTH] = acc[l];
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);

`ifdef GF_EVAL_ZERO_FLAG_EN
    logic [LANES-1:0] zero_reg;

    // Root flags latched from the final accumulator value as the FSM enters DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_reg <= '0;
        end else if ((state != DONE) && (state_nxt == DONE)) begin
            for (int l = 0; l < LANES; l++) begin
                zero_reg[l] <= (acc_nxt[l] == '0);
            end
        end
    end

    assign bus.out_zero = zero_reg;
`endif

endmodule

// File: tb/tb_gf_poly_eval_seq.sv
// tb_gf_poly_eval_seq: directed scenarios plus randomized transactions for
// gf_poly_eval_seq, checked against a direct-sum reference model.
// Checks out_zero as well when GF_EVAL_ZERO_FLAG_EN is defined.
module tb_gf_poly_eval_seq;

    localparam int W    = 8;
    localparam int DMAX = 8;
    localparam int L    = 4;
    localparam int DW   = $clog2(DMAX + 1);
    localparam logic [8:0] FIELD_POLY = 9'h11D;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;

    logic [W-1:0]  coef [DMAX+1];
    logic [W-1:0]  xs   [L];
    logic [DW-1:0] deg;

    always #5 clk = ~clk;

    gf_poly_eval_seq_if #(.SYMB_WIDTH(W), .DEG_MAX(DMAX), .LANES(L)) bus ();

    gf_poly_eval_seq #(
        .SYMB_WIDTH(W),
        .POLY      (285),
        .DEG_MAX   (DMAX),
        .LANES     (L)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Carry-less product followed by polynomial long-division reduction.
    function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-2:0] c;
        c = '0;
        for (int i = 0; i < W; i++) begin
            if (b[i]) c = c ^ ((2*W-1)'(a) << i);
        end
        for (int k = 2*W-2; k >= W; k--) begin
            if (c[k]) c = c ^ ((2*W-1)'(FIELD_POLY) << (k - W));
        end
        return c[W-1:0];
    endfunction

    function automatic int eff_deg();
        return (int'(deg) > DMAX) ? DMAX : int'(deg);
    endfunction

    // p(x) as the plain sum of coef[i] * x^i.
    function automatic logic [W-1:0] ref_eval(input logic [W-1:0] x);
        logic [W-1:0] sum;
        logic [W-1:0] pw;
        sum = '0;
        pw  = 8'd1;
        for (int i = 0; i <= eff_deg(); i++) begin
            sum = sum ^ ref_mul(coef[i], pw);
            pw  = ref_mul(pw, x);
        end
        return sum;
    endfunction

    function automatic logic [L*W-1:0] ref_vec();
        logic [L*W-1:0] v;
        for (int l = 0; l < L; l++) v[l*W +: W] = ref_eval(xs[l]);
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one request and complete the transfer on the next rising edge.
    task automatic apply_stimulus();
        int guard;
        for (int i = 0; i <= DMAX; i++) bus.in_coef[i*W +: W] = coef[i];
        for (int l = 0; l < L; l++) bus.in_x[l*W +: W] = xs[l];
        bus.in_deg   = deg;
        bus.in_valid = 1'b1;
        guard = 0;
        while (!bus.in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 20) check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Count cycles from the transfer until out_valid; compare to the expected latency.
    task automatic wait_result(input string tag);
        int k;
        k = 1;
        while (!bus.out_valid && k < 20) begin
            check({tag, "_busy_in_ready"}, 64'(bus.in_ready), 64'd0);
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_latency"}, 64'(k), 64'(eff_deg() + 1));
    endtask

    // Compare result to the model, hold it for some cycles, then release it.
    task automatic check_output(input string tag, input int hold);
        logic [L*W-1:0] exp_v;
        exp_v = ref_vec();
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_out_val"}, 64'(bus.out_val), 64'(exp_v));
`ifdef GF_EVAL_ZERO_FLAG_EN
        begin
            logic [L-1:0] exp_z;
            for (int l = 0; l < L; l++) exp_z[l] = (exp_v[l*W +: W] == '0);
            check({tag, "_out_zero"}, 64'(bus.out_zero), 64'(exp_z));
        end
`endif
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({tag, "_hold_val"}, 64'(bus.out_val), 64'(exp_v));
            check({tag, "_hold_in_ready"}, 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_release_in_ready"}, 64'(bus.in_ready), 64'd1);
        check({tag, "_release_out_valid"}, 64'(bus.out_valid), 64'd0);
    endtask

    task automatic clear_coef();
        for (int i = 0; i <= DMAX; i++) coef[i] = '0;
    endtask

    initial begin
        bit seen_valid;

        bus.in_valid  = 1'b0;
        bus.in_coef   = '0;
        bus.in_deg    = '0;
        bus.in_x      = '0;
        bus.out_ready = 1'b0;
        clear_coef();
        for (int l = 0; l < L; l++) xs[l] = '0;
        deg = '0;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_val", 64'(bus.out_val), 64'd0);
`ifdef GF_EVAL_ZERO_FLAG_EN
        check("rst_out_zero", 64'(bus.out_zero), 64'd0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        // Scenario 1: p(x) = 1 + x
        clear_coef();
        coef[0] = 8'd1; coef[1] = 8'd1; deg = 4'd1;
        xs[0] = 8'd2; xs[1] = 8'd4; xs[2] = 8'd0; xs[3] = 8'd1;
        apply_stimulus();
        wait_result("s1");
        check("s1_const", 64'(bus.out_val), 64'h0001_0503);
        check_output("s1", 0);

        // Scenario 2: p(x) = x^8 at x = 2
        clear_coef();
        coef[8] = 8'd1; deg = 4'd8;
        for (int l = 0; l < L; l++) xs[l] = 8'd2;
        apply_stimulus();
        wait_result("s2");
        check("s2_const", 64'(bus.out_val), 64'h1D1D_1D1D);
        check_output("s2", 1);

        // Scenario 3: roots at x = 2 and x = 4
        clear_coef();
        coef[0] = 8'd8; coef[1] = 8'd6; coef[2] = 8'd1; deg = 4'd2;
        xs[0] = 8'd2; xs[1] = 8'd4; xs[2] = 8'd3; xs[3] = 8'd0;
        apply_stimulus();
        wait_result("s3");
        check("s3_const", 64'(bus.out_val), 64'h0807_0000);
`ifdef GF_EVAL_ZERO_FLAG_EN
        check("s3_zero_const", 64'(bus.out_zero), 64'b0011);
`endif
        // Scenario 4: consumer stalls for 5 cycles
        check_output("s4", 5);

        // Scenario 5: oversized degree saturates, degree 0 passes coef[0]
        for (int i = 0; i <= DMAX; i++) coef[i] = W'($urandom);
        for (int l = 0; l < L; l++) xs[l] = W'($urandom);
        deg = 4'd12;
        apply_stimulus();
        wait_result("s5_sat");
        check_output("s5_sat", 0);
        deg = 4'd0;
        apply_stimulus();
        wait_result("s5_deg0");
        check("s5_deg0_const", 64'(bus.out_val), 64'({4{coef[0]}}));
        check_output("s5_deg0", 0);

        // Scenario 6: reset during EVAL discards the transaction
        for (int i = 0; i <= DMAX; i++) coef[i] = W'($urandom);
        deg = 4'd8;
        apply_stimulus();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("s6_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("s6_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("s6_rst_out_val", 64'(bus.out_val), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen_valid = 1'b1;
        end
        check("s6_no_out_valid", 64'(seen_valid), 64'd0);
        for (int i = 0; i <= DMAX; i++) coef[i] = W'($urandom);
        deg = 4'd5;
        apply_stimulus();
        wait_result("s6_next");
        check_output("s6_next", 0);

        // Randomized transactions, including x = 0 / 1 and oversized degrees
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i <= DMAX; i++) coef[i] = W'($urandom);
            for (int l = 0; l < L; l++) begin
                case ($urandom_range(0, 5))
                    0:       xs[l] = 8'd0;
                    1:       xs[l] = 8'd1;
                    default: xs[l] = W'($urandom);
                endcase
            end
            deg = DW'($urandom_range(0, 15));
            apply_stimulus();
            wait_result("rnd");
            check_output("rnd", $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
